// File: rtl/io_port_bridge.sv
// CPU in_port/out_port bridge: TX FIFO (CPU -> host) and RX FIFO (host -> CPU), valid/ready on the host side.
// Optional IO_BRIDGE_OVF_CNT_EN builds a saturating counter of dropped TX writes on ovf_cnt.

module io_port_bridge_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH-1:0][7:0]  mem;
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]    count;

    assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // push/pop arrive pre-qualified; a push into a full FIFO is legal only alongside a pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module io_port_bridge #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_out_data,
    input  logic       cpu_out_we,
    output logic [7:0] cpu_in_data,
    output logic       cpu_in_avail,
    input  logic       cpu_in_re,
    output logic [7:0] host_tx_data,
    output logic       host_tx_valid,
    input  logic       host_tx_ready,
    input  logic [7:0] host_rx_data,
    input  logic       host_rx_valid,
    output logic       host_rx_ready,
    input  logic       clr_err,
    output logic       tx_ovf,
    output logic       rx_udf,
    output logic [7:0] ovf_cnt
);
    logic       tx_full, tx_empty, tx_push, tx_pop, tx_drop;
    logic       rx_full, rx_empty, rx_push, rx_pop, rx_udf_ev;
    logic [7:0] tx_head, rx_head;

    // TX may accept a write while full if the host drains in the same cycle
    assign tx_pop    = !tx_empty & host_tx_ready;
    assign tx_push   = cpu_out_we & (!tx_full | tx_pop);
    assign tx_drop   = cpu_out_we & tx_full & !tx_pop;

    // RX ready depends only on registered occupancy, so a pop never frees a slot combinationally
    assign rx_push   = host_rx_valid & !rx_full;
    assign rx_pop    = cpu_in_re & !rx_empty;
    assign rx_udf_ev = cpu_in_re & rx_empty;

    io_port_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(cpu_out_data),
        .head(tx_head), .full(tx_full), .empty(tx_empty)
    );

    io_port_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(host_rx_data),
        .head(rx_head), .full(rx_full), .empty(rx_empty)
    );

    assign host_tx_data  = tx_head;
    assign host_tx_valid = !tx_empty;
    assign host_rx_ready = !rx_full;
    assign cpu_in_avail  = !rx_empty;
    assign cpu_in_data   = rx_empty ? 8'h00 : rx_head;

    // sticky flags: an error event in the same cycle as clr_err wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
        end else begin
            if (tx_drop)      tx_ovf <= 1'b1;
            else if (clr_err) tx_ovf <= 1'b0;
            if (rx_udf_ev)    rx_udf <= 1'b1;
            else if (clr_err) rx_udf <= 1'b0;
        end
    end

`ifdef IO_BRIDGE_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_cnt <= 8'h00;
        end else if (tx_drop) begin
            if (clr_err)               ovf_cnt <= 8'h01;
            else if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'h01;
        end else if (clr_err) begin
            ovf_cnt <= 8'h00;
        end
    end
`else
    assign ovf_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge: directed scenarios plus random traffic against a queue-based model.
// Expected ovf_cnt follows IO_BRIDGE_OVF_CNT_EN.
module tb_io_port_bridge;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef IO_BRIDGE_OVF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] cpu_out_data = '0, host_rx_data = '0;
    logic       cpu_out_we = 0, cpu_in_re = 0, host_tx_ready = 0, host_rx_valid = 0, clr_err = 0;
    logic [7:0] cpu_in_data, host_tx_data, ovf_cnt;
    logic       cpu_in_avail, host_tx_valid, host_rx_ready, tx_ovf, rx_udf;

    io_port_bridge #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk(clk), .rst(rst),
        .cpu_out_data(cpu_out_data), .cpu_out_we(cpu_out_we),
        .cpu_in_data(cpu_in_data), .cpu_in_avail(cpu_in_avail), .cpu_in_re(cpu_in_re),
        .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
        .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
        .clr_err(clr_err), .tx_ovf(tx_ovf), .rx_udf(rx_udf), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_fail = 0;
    logic [7:0] tx_q[$], rx_q[$];
    bit         m_ovf = 0, m_udf = 0;
    int         m_cnt = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("tx_valid", 8'(host_tx_valid), 8'(tx_q.size() > 0));
        if (tx_q.size() > 0) chk("tx_data", host_tx_data, tx_q[0]);
        chk("in_avail", 8'(cpu_in_avail), 8'(rx_q.size() > 0));
        chk("in_data", cpu_in_data, (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        chk("rx_ready", 8'(host_rx_ready), 8'(rx_q.size() < DEPTH));
        chk("tx_ovf", 8'(tx_ovf), 8'(m_ovf));
        chk("rx_udf", 8'(rx_udf), 8'(m_udf));
        chk("ovf_cnt", ovf_cnt, 8'(m_cnt));
    endtask

    // check current outputs, advance the model by the spec rules, then clock; strobes drop after the edge
    task automatic cycle();
        bit tx_pop, tx_full, drop, rx_pop, rx_push, udf;
        check_outputs();
        tx_pop  = (tx_q.size() > 0) && host_tx_ready;
        tx_full = (tx_q.size() == DEPTH);
        drop    = cpu_out_we && tx_full && !tx_pop;
        rx_push = host_rx_valid && (rx_q.size() < DEPTH);
        rx_pop  = cpu_in_re && (rx_q.size() > 0);
        udf     = cpu_in_re && (rx_q.size() == 0);
        if (tx_pop) void'(tx_q.pop_front());
        if (cpu_out_we && !drop) tx_q.push_back(cpu_out_data);
        if (rx_pop) void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(host_rx_data);
        if (drop) m_ovf = 1; else if (clr_err) m_ovf = 0;
        if (udf)  m_udf = 1; else if (clr_err) m_udf = 0;
        if (CNT_EN) begin
            if (drop) m_cnt = clr_err ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
            else if (clr_err) m_cnt = 0;
        end
        @(posedge clk); #1;
        cpu_out_we = 0; cpu_in_re = 0; host_rx_valid = 0; clr_err = 0;
    endtask

    task automatic cpu_write(input logic [7:0] d);
        cpu_out_data = d; cpu_out_we = 1; cycle();
    endtask

    task automatic host_push(input logic [7:0] d);
        host_rx_data = d; host_rx_valid = 1; cycle();
    endtask

    logic [7:0] exp_seq[4];

    initial begin
        // power-on reset
        #12;
        chk("rst_tx_valid", 8'(host_tx_valid), 8'h00);
        chk("rst_rx_ready", 8'(host_rx_ready), 8'h01);
        @(posedge clk); #1; rst = 1;

        // 1: reset mid-stream with TX holding two bytes
        cpu_write(8'hC1); cpu_write(8'hC2); host_push(8'hD1);
        chk("t1_pre_valid", 8'(host_tx_valid), 8'h01);
        #2 rst = 0; #1;
        chk("t1_tx_valid", 8'(host_tx_valid), 8'h00);
        chk("t1_in_avail", 8'(cpu_in_avail), 8'h00);
        chk("t1_in_data", cpu_in_data, 8'h00);
        chk("t1_rx_ready", 8'(host_rx_ready), 8'h01);
        tx_q.delete(); rx_q.delete(); m_ovf = 0; m_udf = 0; m_cnt = 0;
        @(posedge clk); #1; rst = 1;

        // 2: overflow with host stalled, then drain
        host_tx_ready = 0;
        cpu_write(8'h11); cpu_write(8'h22); cpu_write(8'h33); cpu_write(8'h44); cpu_write(8'h55);
        chk("t2_ovf", 8'(tx_ovf), 8'h01);
        chk("t2_cnt", ovf_cnt, CNT_EN ? 8'h01 : 8'h00);
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        host_tx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_seq", host_tx_data, exp_seq[i]);
            cycle();
        end
        chk("t2_empty", 8'(host_tx_valid), 8'h00);
        host_tx_ready = 0;

        // 3: write into full TX while host pops
        clr_err = 1; cycle();
        cpu_write(8'h01); cpu_write(8'h02); cpu_write(8'h03); cpu_write(8'h04);
        host_tx_ready = 1; cpu_write(8'h66);
        chk("t3_no_ovf", 8'(tx_ovf), 8'h00);
        exp_seq = '{8'h02, 8'h03, 8'h04, 8'h66};
        for (int i = 0; i < 4; i++) begin
            chk("t3_seq", host_tx_data, exp_seq[i]);
            cycle();
        end
        host_tx_ready = 0;

        // 4: fill RX, then CPU drains it
        for (int i = 0; i < 4; i++) host_push(8'hA0 + 8'(i));
        chk("t4_ready", 8'(host_rx_ready), 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk("t4_seq", cpu_in_data, 8'hA0 + 8'(i));
            cpu_in_re = 1; cycle();
        end
        chk("t4_data0", cpu_in_data, 8'h00);
        chk("t4_avail0", 8'(cpu_in_avail), 8'h00);

        // 5: underflow read coinciding with host push
        host_rx_data = 8'h5A; host_rx_valid = 1; cpu_in_re = 1; cycle();
        chk("t5_udf", 8'(rx_udf), 8'h01);
        chk("t5_data", cpu_in_data, 8'h5A);
        chk("t5_avail", 8'(cpu_in_avail), 8'h01);
        cpu_in_re = 1; cycle();

        // 6: counter saturation and clear colliding with a drop
        clr_err = 1; cycle();
        for (int i = 0; i < DEPTH; i++) cpu_write(8'(i));
        for (int i = 0; i < 300; i++) cpu_write(8'hEE);
        chk("t6_sat", ovf_cnt, CNT_EN ? 8'hFF : 8'h00);
        clr_err = 1; cpu_write(8'hEF);
        chk("t6_clr_ovf", 8'(tx_ovf), 8'h01);
        chk("t6_clr_cnt", ovf_cnt, CNT_EN ? 8'h01 : 8'h00);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            cpu_out_data  = 8'($urandom);
            host_rx_data  = 8'($urandom);
            cpu_out_we    = ($urandom_range(0, 9) < 5);
            host_tx_ready = ($urandom_range(0, 9) < 4);
            host_rx_valid = ($urandom_range(0, 9) < 5);
            cpu_in_re     = ($urandom_range(0, 9) < 4);
            clr_err       = ($urandom_range(0, 49) == 0);
            cycle();
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
